// File: rtl/mem_fill_ctrl.sv
// Memory-side initiator for the cache: block fills on a miss and single-word write-through stores.
// Optional macro MEM_FILL_CRIT_WORD_FIRST_EN: a fill starts at the missing word and wraps around the block.
module mem_fill_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                miss_req,
    input  logic [ADDR_WIDTH-1:0]               miss_addr,
    input  logic                                wr_req,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [15:0]                         wr_data,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_en,
    output logic                                mem_wr,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [15:0]                         mem_wdata,
    input  logic [15:0]                         mem_rdata,
    output logic                                cache_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]  cache_word,
    output logic [15:0]                         cache_wdata,
    output logic                                tag_we
);

    localparam int OFF = $clog2(WORDS_PER_BLOCK);
    localparam int WW  = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]                   state_reg,     state_next;
    logic [OFF-1:0]               word_idx_reg,  word_idx_next;
    logic [OFF-1:0]               fill_cnt_reg,  fill_cnt_next;
    logic [WW-1:0]                wait_cnt_reg,  wait_cnt_next;
    logic                         is_fill_reg,   is_fill_next;
    logic [ADDR_WIDTH-OFF-2:0]    blk_addr_reg,  blk_addr_next;
    logic [ADDR_WIDTH-2:0]        wr_addr_reg,   wr_addr_next;
    logic [15:0]                  wr_data_reg,   wr_data_next;

    logic [OFF-1:0] start_idx;
    logic           wait_last;
    logic           fill_last;

    // Word offset bits of miss_addr only matter when the fill starts at the critical word.
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
    assign start_idx = miss_addr[OFF:1];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[0], wr_addr[0]};
`else
    assign start_idx = '0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[OFF:0], wr_addr[0]};
`endif

    assign wait_last = (wait_cnt_reg == WW'(MEM_LAT));
    assign fill_last = (fill_cnt_reg == OFF'(WORDS_PER_BLOCK - 1));

    always_comb begin
        state_next    = state_reg;
        word_idx_next = word_idx_reg;
        fill_cnt_next = fill_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        is_fill_next  = is_fill_reg;
        blk_addr_next = blk_addr_reg;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        case (state_reg)
            S_IDLE: begin
                // Store wins a tie so a following fill observes the stored word.
                if (wr_req) begin
                    state_next    = S_WR;
                    wait_cnt_next = '0;
                    is_fill_next  = 1'b0;
                    wr_addr_next  = wr_addr[ADDR_WIDTH-1:1];
                    wr_data_next  = wr_data;
                end else if (miss_req) begin
                    state_next    = S_RD;
                    wait_cnt_next = '0;
                    word_idx_next = start_idx;
                    fill_cnt_next = '0;
                    is_fill_next  = 1'b1;
                    blk_addr_next = miss_addr[ADDR_WIDTH-1:OFF+1];
                end
            end
            S_WR: begin
                if (wait_last) begin
                    state_next    = S_FIN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_RD: begin
                if (wait_last) begin
                    wait_cnt_next = '0;
                    if (fill_last) begin
                        state_next = S_FIN;
                    end else begin
                        word_idx_next = word_idx_reg + 1'b1;
                        fill_cnt_next = fill_cnt_reg + 1'b1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            word_idx_reg <= '0;
            fill_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            is_fill_reg  <= 1'b0;
            blk_addr_reg <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            word_idx_reg <= word_idx_next;
            fill_cnt_reg <= fill_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            is_fill_reg  <= is_fill_next;
            blk_addr_reg <= blk_addr_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_FIN);
    assign tag_we      = (state_reg == S_FIN) && is_fill_reg;
    assign mem_en      = (state_reg == S_WR) || (state_reg == S_RD);
    assign mem_wr      = (state_reg == S_WR);
    assign mem_wdata   = (state_reg == S_WR) ? wr_data_reg : 16'h0000;
    assign cache_we    = (state_reg == S_RD) && wait_last;
    assign cache_word  = word_idx_reg;
    assign cache_wdata = mem_rdata;

    always_comb begin
        mem_addr = '0;
        if (state_reg == S_WR) begin
            mem_addr = {wr_addr_reg, 1'b0};
        end else if (state_reg == S_RD) begin
            mem_addr = {blk_addr_reg, word_idx_reg, 1'b0};
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Bench for mem_fill_ctrl: two instances (MEM_LAT 0 and 3) on private memories, checked cycle by cycle.
module tb_mem_fill_ctrl;

    localparam int W    = 8;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst_n;
    logic        miss_req    [2];
    logic [15:0] miss_addr   [2];
    logic        wr_req      [2];
    logic [15:0] wr_addr     [2];
    logic [15:0] wr_data     [2];
    logic        busy        [2];
    logic        done        [2];
    logic        mem_en      [2];
    logic        mem_wr      [2];
    logic [15:0] mem_addr    [2];
    logic [15:0] mem_wdata   [2];
    logic [15:0] mem_rdata   [2];
    logic        cache_we    [2];
    logic [2:0]  cache_word  [2];
    logic [15:0] cache_wdata [2];
    logic        tag_we      [2];

    logic [15:0] ref_mem [2][32768];

    int total;
    int bad;

    function automatic logic [15:0] init_word(input int i);
        if (i >= 'h918 && i < 'h918 + W) return 16'(16'hA000 + (i - 'h918));
        return 16'(i) ^ 16'h5A00;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [15:0] mem [32768];

        mem_fill_ctrl #(
            .ADDR_WIDTH      (16),
            .WORDS_PER_BLOCK (W),
            .MEM_LAT         ((gi == 0) ? 0 : LAT1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .miss_req    (miss_req[gi]),
            .miss_addr   (miss_addr[gi]),
            .wr_req      (wr_req[gi]),
            .wr_addr     (wr_addr[gi]),
            .wr_data     (wr_data[gi]),
            .busy        (busy[gi]),
            .done        (done[gi]),
            .mem_en      (mem_en[gi]),
            .mem_wr      (mem_wr[gi]),
            .mem_addr    (mem_addr[gi]),
            .mem_wdata   (mem_wdata[gi]),
            .mem_rdata   (mem_rdata[gi]),
            .cache_we    (cache_we[gi]),
            .cache_word  (cache_word[gi]),
            .cache_wdata (cache_wdata[gi]),
            .tag_we      (tag_we[gi])
        );

        assign mem_rdata[gi] = mem[mem_addr[gi][15:1]];

        initial begin
            for (int i = 0; i < 32768; i++) mem[i] = init_word(i);
        end

        always @(posedge clk) begin
            if (mem_en[gi] && mem_wr[gi]) mem[mem_addr[gi][15:1]] <= mem_wdata[gi];
        end
    end

    // Every output is zero (cache_word included) while reset holds.
    task automatic check_zero(input int d, input string name);
        logic [63:0] act;
        act = {busy[d], done[d], mem_en[d], mem_wr[d], mem_addr[d], mem_wdata[d],
               cache_we[d], cache_word[d], tag_we[d]};
        total++;
        if (act != 64'd0) begin
            bad++;
            $display("FAIL %s dut=%0d outputs=%h required=0", name, d, act);
        end
    endtask

    // One request from cycle 0; every following cycle compared with the timeline derived from the rules.
    task automatic txn(input int d, input bit do_wr, input bit do_miss,
                       input logic [15:0] waddr, input logic [15:0] wdata,
                       input logic [15:0] maddr, output int done_cyc, output bit tag_seen);
        int lat, n, limit, start, k, idx;
        logic [63:0] act, exp;
        logic e_busy, e_done, e_en, e_wr, e_cwe, e_tag;
        logic [15:0] e_addr, e_wdata, e_cwd;
        logic [2:0] e_cw;
        lat = (d == 0) ? 0 : LAT1;
        n = W * (lat + 1);
        limit = do_wr ? lat + 3 : n + 2;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
        start = int'(maddr >> 1) % W;
`else
        start = 0;
`endif
        wr_req[d] = do_wr;
        wr_addr[d] = waddr;
        wr_data[d] = wdata;
        miss_req[d] = do_miss;
        miss_addr[d] = maddr;
        done_cyc = -1;
        tag_seen = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            @(negedge clk);
            e_addr = 16'h0; e_wdata = 16'h0; e_cw = 3'd0; e_cwd = 16'h0;
            if (do_wr) begin
                e_busy = (c <= lat + 2);
                e_en = (c <= lat + 1);
                e_wr = e_en;
                e_done = (c == lat + 2);
                e_tag = 1'b0;
                e_cwe = 1'b0;
                if (e_en) begin
                    e_addr = waddr & 16'hFFFE;
                    e_wdata = wdata;
                end
            end else begin
                e_busy = (c <= n + 1);
                e_en = (c <= n);
                e_wr = 1'b0;
                e_done = (c == n + 1);
                e_tag = e_done;
                e_cwe = e_en && ((c % (lat + 1)) == 0);
                if (e_en) begin
                    k = (c - 1) / (lat + 1);
                    idx = (start + k) % W;
                    e_addr = (maddr & ~16'(2 * W - 1)) | 16'(idx * 2);
                    if (e_cwe) begin
                        e_cw = 3'(idx);
                        e_cwd = ref_mem[d][e_addr >> 1];
                    end
                end
            end
            exp = {7'd0, e_busy, e_done, e_en, e_wr, e_addr, e_wdata, e_cwe, e_cw, e_cwd, e_tag};
            act = {7'd0, busy[d], done[d], mem_en[d], mem_wr[d],
                   mem_en[d] ? mem_addr[d] : 16'h0, mem_wr[d] ? mem_wdata[d] : 16'h0,
                   cache_we[d], cache_we[d] ? cache_word[d] : 3'd0,
                   cache_we[d] ? cache_wdata[d] : 16'h0, tag_we[d]};
            total++;
            if (act != exp) begin
                bad++;
                $display("FAIL cycle dut=%0d c=%0d got=%h required=%h", d, c, act, exp);
            end
            if (done[d] && done_cyc < 0) begin
                done_cyc = c;
                tag_seen = tag_we[d];
                wr_req[d] = 1'b0;
                miss_req[d] = 1'b0;
            end
        end
        wr_req[d] = 1'b0;
        miss_req[d] = 1'b0;
        if (do_wr) ref_mem[d][waddr >> 1] = wdata;
    endtask

    typedef struct {
        int          d;
        bit          do_wr;
        bit          do_miss;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] maddr;
        int          exp_done;
        bit          exp_tag;
    } vec_t;

    vec_t vecs [8];

    task automatic run_one(input vec_t v, input string name);
        int dc;
        bit tg;
        txn(v.d, v.do_wr, v.do_miss, v.waddr, v.wdata, v.maddr, dc, tg);
        total++;
        if (dc != v.exp_done || tg != v.exp_tag) begin
            bad++;
            $display("FAIL %s dut=%0d done_cycle=%0d tag=%0b required done_cycle=%0d tag=%0b",
                     name, v.d, dc, tg, v.exp_done, v.exp_tag);
        end else begin
            $display("txn %s dut=%0d wr=%0b miss=%0b done_cycle=%0d tag=%0b",
                     name, v.d, v.do_wr, v.do_miss, dc, tg);
        end
    endtask

    initial begin
        vec_t v;
        logic [15:0] rd;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            miss_req[d] = 1'b0; miss_addr[d] = 16'h0;
            wr_req[d] = 1'b0; wr_addr[d] = 16'h0; wr_data[d] = 16'h0;
            for (int i = 0; i < 32768; i++) ref_mem[d][i] = init_word(i);
        end

        vecs[0] = '{0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1236, 9, 1'b1};
        vecs[1] = '{0, 1'b1, 1'b0, 16'h0041, 16'hBEEF, 16'h0000, 2, 1'b0};
        vecs[2] = '{0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0040, 9, 1'b1};
        vecs[3] = '{0, 1'b1, 1'b1, 16'h1232, 16'h1234, 16'h1236, 2, 1'b0};
        vecs[4] = '{0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1236, 9, 1'b1};
        vecs[5] = '{0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 9, 1'b1};
        vecs[6] = '{1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1236, 33, 1'b1};
        vecs[7] = '{1, 1'b1, 1'b0, 16'h0041, 16'hBEEF, 16'h0000, 5, 1'b0};

        repeat (3) @(negedge clk);
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        rd = g_dut[0].mem[16'h0020];
        total++;
        if (rd != 16'hBEEF) begin
            bad++;
            $display("FAIL store_readback got=%h required=beef", rd);
        end

        // Reset in cycle 4 of a fill aborts it with no tag write.
        miss_req[0] = 1'b1;
        miss_addr[0] = 16'h1236;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (!(busy[0] && mem_en[0])) begin
            bad++;
            $display("FAIL midfill_active busy=%0b mem_en=%0b required 1 1", busy[0], mem_en[0]);
        end
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_reset");
        miss_req[0] = 1'b0;
        @(negedge clk);
        check_zero(0, "reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero(0, "after_release");
        v = '{0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1236, 9, 1'b1};
        run_one(v, "refill");

        for (int i = 0; i < 24; i++) begin
            int kind;
            v.d = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            v.do_wr = (kind != 1);
            v.do_miss = (kind != 0);
            v.waddr = 16'h1200 + 16'($urandom_range(0, 63));
            v.wdata = 16'($urandom);
            v.maddr = 16'h1200 + 16'($urandom_range(0, 63));
            v.exp_done = v.do_wr ? ((v.d == 0) ? 2 : LAT1 + 2) : ((v.d == 0) ? W + 1 : W * (LAT1 + 1) + 1);
            v.exp_tag = !v.do_wr;
            run_one(v, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
Name: mem_fill_ctrl

Overview:
- Memory-side initiator for the data/instruction cache. Drives the single-port, 16-bit, byte-addressed, word-aligned memory (enable/wr/addr/data_in; combinational read data).
- Services two request types, one at a time:
  - cache-block fill on a miss: sequential word reads written into the cache data array, then a tag write;
  - single-word write-through store.
- Sits between the cache controller and the memory; owns all memory-port traffic, so a read and a write are never issued concurrently.

Parameters:
- ADDR_WIDTH, 16, byte-address width of all address ports.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of 2, range 2..16; OFF = log2(WORDS_PER_BLOCK).
- MEM_LAT, 0, extra wait cycles per memory access; each access holds the port for MEM_LAT+1 cycles.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  1  fill request; level; held by requester until done.
- miss_addr  in  ADDR_WIDTH  byte address of the missing access.
- wr_req  in  1  write-through request; level; held until done.
- wr_addr  in  ADDR_WIDTH  store byte address; bit 0 ignored.
- wr_data  in  16  store data.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory byte address; bit 0 always 0.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- cache_we  out  1  cache data-array word write.
- cache_word  out  OFF  word index within the block.
- cache_wdata  out  16  word to cache; equals mem_rdata.
- tag_we  out  1  tag/valid write for the block at miss_addr.

Behaviour:
- Reset: async on rst_n low. State IDLE; word_idx=0, wait_cnt=0. busy, done, mem_en, mem_wr, cache_we, tag_we = 0; mem_addr = 0, mem_wdata = 0. Reset mid-operation aborts immediately: no tag_we, and partially written cache words are left invalid.
- States: IDLE, WR, RD, FIN. Outputs are decoded from registered state and counters (Moore), except cache_wdata.
- IDLE: requests are sampled only here.
  - wr_req=1 → WR (wr_req has priority over a simultaneous miss_req, so a fill sees the prior store).
  - else miss_req=1 → RD, with word_idx = start index and wait_cnt = 0. miss_addr and wr_addr/wr_data are captured into registers on acceptance.
- WR: mem_en=1, mem_wr=1, mem_addr={wr_addr[AW-1:1],0}, mem_wdata=wr_data (captured values). Held MEM_LAT+1 cycles → FIN.
- RD: mem_en=1, mem_wr=0, mem_addr={miss_addr[AW-1:OFF+1], word_idx, 0}.
  - wait_cnt counts 0..MEM_LAT. On the cycle wait_cnt==MEM_LAT: cache_we=1, cache_word=word_idx, cache_wdata=mem_rdata.
  - After the last word → FIN; otherwise word_idx increments modulo WORDS_PER_BLOCK and wait_cnt clears.
  - Exactly WORDS_PER_BLOCK writes per fill.
- FIN: done=1 for one cycle; tag_we=1 only when finishing a fill (never after WR); → IDLE. The requester drops its request in the done cycle. A request still high in IDLE is treated as new.
- Latency, request seen in cycle 0:
  - fill: RD occupies cycles 1..W*(MEM_LAT+1); done at W*(MEM_LAT+1)+1 (cycle 9 for defaults);
  - write: done at MEM_LAT+2.
- Never mem_en with mem_wr toggling within one access. mem_en=0 in IDLE/FIN.

Optional Feature:
- Macro: MEM_FILL_CRIT_WORD_FIRST_EN.
- Defined: start index = miss_addr[OFF:1]; fill wraps through block end back to word 0 and ends at start-1.
- Undefined: start index = 0; words filled 0..W-1 in order.
- Latency, done timing and write count are identical in both cases.

Test Plan:
- Defaults, miss_addr=0x1236, memory word n at 0x1230+2n = 0xA000+n → cache_word 0..7 with data 0xA000..0xA007 on cycles 1..8; tag_we=done=1 cycle 9; busy cycles 1..9.
- Macro defined, same miss → order 3,4,5,6,7,0,1,2; first mem_addr 0x1236; wraps to 0x1230; done cycle 9.
- wr_req with wr_addr=0x0041, wr_data=0xBEEF, MEM_LAT=2 → mem_en=mem_wr=1 cycles 1..3 at addr 0x0040; done cycle 4; tag_we stays 0; memory then reads 0xBEEF.
- wr_req and miss_req both high in IDLE → write completes (done), then fill starts after requester reasserts; no overlapping mem_en.
- rst_n low in cycle 4 of a fill → all outputs 0 asynchronously; no tag_we; a new miss after release restarts at start index.
- MEM_LAT=3 fill → each mem_addr held 4 cycles; cache_we only on 4th; done cycle 33.
